// File: rtl/exmem_arb_pkg.sv
// Shared types and constants for the user-BRAM arbiter.
// Imported by the arbiter top and its round-robin picker.
package exmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        ACK  = 2'd2
    } state_t;

    localparam logic REQ_WB  = 1'b0;
    localparam logic REQ_ACC = 1'b1;

    localparam int DEFAULT_DELAYS = 10;

endpackage

// File: rtl/exmem_rr_pick.sv
// Two-way round-robin picker: on contention the requester
// that did not finish last wins.
module exmem_rr_pick
    import exmem_arb_pkg::*;
(
    input  logic [1:0] i_valid,
    input  logic       i_last,
    output logic [1:0] o_pick,
    output logic       o_pick_valid
);

    always_comb begin
        o_pick = 2'b00;
        unique case (i_valid)
            2'b01:   o_pick = 2'b01;
            2'b10:   o_pick = 2'b10;
            2'b11:   o_pick = (i_last == REQ_ACC) ? 2'b01 : 2'b10;
            default: o_pick = 2'b00;
        endcase
    end

    assign o_pick_valid = |i_valid;

endmodule

// File: rtl/exmem_arbiter.sv
// Arbiter/sequencer for the single-port user BRAM: round-robin
// between Wishbone and accelerator, with emulated access latency.
module exmem_arbiter
    import exmem_arb_pkg::*;
#(
    parameter int ADDR_W = 24,
    parameter int DELAYS = DEFAULT_DELAYS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              r0_valid,
    input  logic [3:0]        r0_we,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [31:0]       r0_wdata,
    output logic              r0_ready,
    output logic [31:0]       r0_rdata,
    input  logic              r1_valid,
    input  logic [3:0]        r1_we,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [31:0]       r1_wdata,
    output logic              r1_ready,
    output logic [31:0]       r1_rdata,
    output logic              mem_en,
    output logic [3:0]        mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output logic [1:0]        grant,
    output logic              busy
);

    localparam int CNT_W = $clog2(DELAYS + 1);
    localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(DELAYS);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_own;
    logic             r_last;
    logic [31:0]      r_rdata0;
    logic [31:0]      r_rdata1;

    logic [1:0]       w_pick;
    logic             w_pick_vld;
    logic             w_own_vld;
    logic             w_done;
    logic [3:0]       w_own_we;

    exmem_rr_pick u_pick (
        .i_valid      ({r1_valid, r0_valid}),
        .i_last       (r_last),
        .o_pick       (w_pick),
        .o_pick_valid (w_pick_vld)
    );

    assign w_own_vld = (r_own[0] & r0_valid)
                     | (r_own[1] & r1_valid);
    assign w_done    = (r_cnt == LP_LAST);
    assign w_own_we  = r_own[1] ? r1_we : r0_we;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE: begin
                if (w_pick_vld) begin
                    w_state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (!w_own_vld) begin
                    w_state_nxt = IDLE;
                end else if (w_done) begin
                    w_state_nxt = ACK;
                end
            end
            ACK:     w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Owner, counter, round-robin history and read-data capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt    <= '0;
            r_own    <= 2'b00;
            r_last   <= REQ_ACC;
            r_rdata0 <= '0;
            r_rdata1 <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    r_cnt <= '0;
                    if (w_pick_vld) begin
                        r_own <= w_pick;
                    end
                end
                BUSY: begin
                    if (!w_own_vld) begin
                        r_cnt <= '0;
                        r_own <= 2'b00;
                    end else if (w_done) begin
                        r_cnt  <= '0;
                        r_last <= r_own[1];
                        if (r_own[0]) begin
                            r_rdata0 <= mem_rdata;
                        end
                        if (r_own[1]) begin
                            r_rdata1 <= mem_rdata;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ACK: begin
                    r_cnt <= '0;
                    r_own <= 2'b00;
                end
                default: begin
                    r_cnt <= '0;
                    r_own <= 2'b00;
                end
            endcase
        end
    end

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 4'b0000;
        grant     = 2'b00;
        r0_ready  = 1'b0;
        r1_ready  = 1'b0;
        busy      = (r_state != IDLE);
        mem_addr  = r_own[1] ? r1_addr  : r0_addr;
        mem_wdata = r_own[1] ? r1_wdata : r0_wdata;
        unique case (r_state)
            BUSY: begin
                mem_en = 1'b1;
                grant  = r_own;
                if (w_done && w_own_vld) begin
                    mem_we = w_own_we;
                end
            end
            ACK: begin
                r0_ready = r_own[0];
                r1_ready = r_own[1];
            end
            default: begin
                mem_en = 1'b0;
            end
        endcase
    end

    assign r0_rdata = r_rdata0;
    assign r1_rdata = r_rdata1;

endmodule

// File: tb/tb_exmem_arbiter.sv
// Directed bench for exmem_arbiter with a behavioural
// one-cycle-read byte-write BRAM.
module tb_exmem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        r0_valid = 1'b0;
  logic [3:0]  r0_we = 4'h0;
  logic [23:0] r0_addr = '0;
  logic [31:0] r0_wdata = '0;
  logic        r0_ready;
  logic [31:0] r0_rdata;
  logic        r1_valid = 1'b0;
  logic [3:0]  r1_we = 4'h0;
  logic [23:0] r1_addr = '0;
  logic [31:0] r1_wdata = '0;
  logic        r1_ready;
  logic [31:0] r1_rdata;
  logic        mem_en;
  logic [3:0]  mem_we;
  logic [23:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic [1:0]  grant;
  logic        busy;

  logic        tb_init = 1'b1;
  logic [31:0] mem [0:255];

  int n_asrt = 0;
  int n_fail = 0;

  exmem_arbiter #(.ADDR_W(24), .DELAYS(10)) dut (
    .clk       (clk),
    .rst       (rst),
    .r0_valid  (r0_valid),
    .r0_we     (r0_we),
    .r0_addr   (r0_addr),
    .r0_wdata  (r0_wdata),
    .r0_ready  (r0_ready),
    .r0_rdata  (r0_rdata),
    .r1_valid  (r1_valid),
    .r1_we     (r1_we),
    .r1_addr   (r1_addr),
    .r1_wdata  (r1_wdata),
    .r1_ready  (r1_ready),
    .r1_rdata  (r1_rdata),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .grant     (grant),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (tb_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
      mem[8'h10] <= 32'hDEADBEEF;
      mem[8'h20] <= 32'h12345678;
      mem[8'h30] <= 32'h0BADF00D;
    end else if (mem_en) begin
      for (int b = 0; b < 4; b++)
        if (mem_we[b])
          mem[mem_addr[7:0]][b*8 +: 8] <= mem_wdata[b*8 +: 8];
      mem_rdata <= mem[mem_addr[7:0]];
    end
  end

  task automatic chk(
    input string       tag,
    input logic [63:0] obs,
    input logic [63:0] exp
  );
    n_asrt++;
    if (obs !== exp) begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic xact(
    input  bit          req,
    input  logic [3:0]  we,
    input  logic [23:0] a,
    input  logic [31:0] wd,
    output int          lat,
    output int          wep,
    output int          wecyc,
    output logic [31:0] rd,
    output bit          oth
  );
    lat = 0; wep = 0; wecyc = 0; rd = '0; oth = 1'b0;
    if (req) begin
      r1_valid = 1'b1; r1_we = we; r1_addr = a; r1_wdata = wd;
    end else begin
      r0_valid = 1'b1; r0_we = we; r0_addr = a; r0_wdata = wd;
    end
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (mem_we != 4'h0) begin
        wep++;
        wecyc = c;
      end
      if (req ? r0_ready : r1_ready) oth = 1'b1;
      if (req ? r1_ready : r0_ready) begin
        lat = c;
        rd = req ? r1_rdata : r0_rdata;
        break;
      end
    end
    r0_valid = 1'b0; r1_valid = 1'b0;
    r0_we = 4'h0; r1_we = 4'h0;
    @(negedge clk);
  endtask

  initial begin
    int          lat, wep, wecyc, t0, t1, n;
    logic [31:0] rd, rd1;
    bit          oth;
    logic [1:0]  g [0:40];
    int          ord [8];
    logic        b6, b7;
    logic [1:0]  g8;
    logic [1:0]  g9;
    logic        busy9, en9, rdy9;
    logic [3:0]  we9;
    logic [31:0] rd9a, rd9b;

    repeat (3) @(negedge clk);
    tb_init = 1'b0;
    chk("rst_grant", grant, 2'b00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ready", {r1_ready, r0_ready}, 2'b00);
    chk("rst_rdata0", r0_rdata, 32'h0);
    chk("rst_mem_en", mem_en, 1'b0);
    chk("rst_mem_we", mem_we, 4'h0);
    rst = 1'b0;
    @(negedge clk);

    xact(1'b0, 4'h0, 24'h10, 32'h0, lat, wep, wecyc, rd, oth);
    chk("t1_latency", lat, 12);
    chk("t1_rdata", rd, 32'hDEADBEEF);
    chk("t1_no_write", wep, 0);
    chk("t1_no_r1_ready", oth, 1'b0);

    xact(1'b1, 4'b0011, 24'h20, 32'hA5A5A5A5,
         lat, wep, wecyc, rd, oth);
    chk("t2_latency", lat, 12);
    chk("t2_we_pulses", wep, 1);
    chk("t2_we_cycle", wecyc, 11);
    chk("t2_no_r0_ready", oth, 1'b0);
    xact(1'b0, 4'h0, 24'h20, 32'h0, lat, wep, wecyc, rd, oth);
    chk("t2_readback", rd, 32'h1234A5A5);

    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    t0 = 0; t1 = 0; rd1 = '0;
    r0_valid = 1'b1; r0_addr = 24'h10;
    r1_valid = 1'b1; r1_addr = 24'h20;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      g[c] = grant;
      if (r0_ready) begin
        t0 = c; r0_valid = 1'b0;
      end
      if (r1_ready) begin
        t1 = c; rd1 = r1_rdata; r1_valid = 1'b0;
      end
    end
    chk("t3_r0_ready_cyc", t0, 12);
    chk("t3_r1_ready_cyc", t1, 25);
    chk("t3_grant_c1", g[1], 2'b01);
    chk("t3_grant_c13", g[13], 2'b00);
    chk("t3_grant_c14", g[14], 2'b10);
    chk("t3_r1_rdata", rd1, 32'h1234A5A5);

    for (int i = 0; i < 8; i++) ord[i] = -1;
    n = 0;
    r0_valid = 1'b1; r0_addr = 24'h10;
    r1_valid = 1'b1; r1_addr = 24'h20;
    for (int c = 1; c <= 130 && n < 8; c++) begin
      @(negedge clk);
      if (r0_ready) begin
        ord[n] = 0; n++;
      end
      if (r1_ready) begin
        ord[n] = 1; n++;
      end
    end
    r0_valid = 1'b0; r1_valid = 1'b0;
    @(negedge clk);
    chk("t4_count", n, 8);
    for (int i = 0; i < 8; i++)
      chk("t4_order", ord[i], i % 2);

    wep = 0; oth = 1'b0; t0 = 0; rd = '0;
    b6 = 1'b0; b7 = 1'b1; g8 = 2'b00;
    r1_valid = 1'b1; r1_we = 4'hF;
    r1_addr = 24'h30; r1_wdata = 32'hA5A5A5A5;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (mem_we != 4'h0) wep++;
      if (r1_ready) oth = 1'b1;
      if (c == 3) begin
        r0_valid = 1'b1; r0_addr = 24'h10; r0_we = 4'h0;
      end
      if (c == 6) begin
        b6 = busy; r1_valid = 1'b0;
      end
      if (c == 7) b7 = busy;
      if (c == 8) g8 = grant;
      if (r0_ready && t0 == 0) begin
        t0 = c; rd = r0_rdata; r0_valid = 1'b0;
      end
    end
    r1_we = 4'h0;
    chk("t5_busy_before", b6, 1'b1);
    chk("t5_idle_after", b7, 1'b0);
    chk("t5_r0_grant", g8, 2'b01);
    chk("t5_no_write", wep, 0);
    chk("t5_no_r1_ready", oth, 1'b0);
    chk("t5_r0_ready_cyc", t0, 19);
    chk("t5_r0_rdata", rd, 32'hDEADBEEF);
    xact(1'b0, 4'h0, 24'h30, 32'h0, lat, wep, wecyc, rd, oth);
    chk("t5_mem_unchanged", rd, 32'h0BADF00D);

    wep = 0;
    g9 = 2'b11; busy9 = 1'b1; en9 = 1'b1; rdy9 = 1'b1;
    we9 = 4'hF; rd9a = '1; rd9b = '1;
    r1_valid = 1'b1; r1_we = 4'hF;
    r1_addr = 24'h40; r1_wdata = 32'h11112222;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      if (mem_we != 4'h0) wep++;
      if (c == 8) rst = 1'b1;
      if (c == 9) begin
        g9 = grant; busy9 = busy; en9 = mem_en;
        rdy9 = r0_ready | r1_ready; we9 = mem_we;
        rd9a = r0_rdata; rd9b = r1_rdata;
        rst = 1'b0; r1_valid = 1'b0; r1_we = 4'h0;
      end
    end
    chk("t6_grant", g9, 2'b00);
    chk("t6_busy", busy9, 1'b0);
    chk("t6_mem_en", en9, 1'b0);
    chk("t6_mem_we", we9, 4'h0);
    chk("t6_ready", rdy9, 1'b0);
    chk("t6_r0_rdata", rd9a, 32'h0);
    chk("t6_r1_rdata", rd9b, 32'h0);
    chk("t6_no_write", wep, 0);
    @(negedge clk);
    xact(1'b0, 4'h0, 24'h40, 32'h0, lat, wep, wecyc, rd, oth);
    chk("t6_post_latency", lat, 12);
    chk("t6_mem_unchanged", rd, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_asrt, n_fail);
    $finish;
  end

endmodule

// File: doc/exmem_arbiter.md
Name: exmem_arbiter

Overview:
Two-requester arbiter and sequencer for the single-port user BRAM behind the Wishbone user window. Requester 0 is the Wishbone slave path; requester 1 is an on-chip accelerator/DMA master. The block grants the BRAM to one requester at a time, using round-robin. It emulates external-memory latency with a DELAYS-cycle wait counter and returns a one-cycle ready pulse with the read data.

Parameters:
- ADDR_W, 24, word/byte address width passed through to the BRAM A0 port (zero-extended to 32 by the parent).
- DELAYS, 10, number of wait cycles per access. Legal range is 1..65535; 0 is illegal.
- CNT_W, $clog2(DELAYS+1), width of the wait counter (derived, not overridden).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- r0_valid  in  1  requester 0 access request; held until r0_ready.
- r0_we  in  4  byte write strobes; 0 means read.
- r0_addr  in  ADDR_W  address.
- r0_wdata  in  32  write data.
- r0_ready  out  1  one-cycle completion pulse.
- r0_rdata  out  32  read data, valid while r0_ready=1.
- r1_valid, r1_we, r1_addr, r1_wdata, r1_ready, r1_rdata: same widths and meaning for requester 1.
- mem_en  out  1  BRAM enable (EN0).
- mem_we  out  4  BRAM byte write enables (WE0).
- mem_addr  out  ADDR_W  BRAM address.
- mem_wdata  out  32  BRAM write data (Di0).
- mem_rdata  in  32  BRAM read data (Do0, one-cycle registered read).
- grant  out  2  one-hot current owner; 00 when idle.
- busy  out  1  high in BUSY or ACK.

Behaviour:
- Reset values:
  - state=IDLE, cnt=0, last=1 (so requester 0 wins first), grant=00, busy=0.
  - r0_ready=r1_ready=0, r0_rdata=r1_rdata=0.
  - mem_en=0, mem_we=0.
- IDLE:
  - If exactly one valid is high, register grant to that requester and go to BUSY with cnt=0.
  - If both are high, grant the requester not equal to last.
  - If none is high, stay in IDLE.
- BUSY:
  - mem_addr and mem_wdata are combinationally muxed from the granted requester. mem_en=1.
  - cnt increments each cycle.
  - When cnt==DELAYS: assert mem_we = granted requester's we for this single cycle only, so each write happens exactly once. Capture mem_rdata into that requester's rdata register, set last=granted, and go to ACK.
- ACK:
  - Granted requester's ready=1 for exactly one cycle; the other ready stays 0.
  - mem_en=0, grant cleared, go to IDLE.
- Latency: valid first sampled in IDLE at cycle t → ready at cycle t+DELAYS+2. With DELAYS=10, that is cycle t+12.
- Back-to-back: at least one IDLE cycle separates transactions. Consecutive grants start 13 cycles apart with DELAYS=10.
- Abort: if the granted requester's valid falls during BUSY, go to IDLE next cycle.
  - No ready and no write. mem_we is gated by valid, including on the cnt==DELAYS cycle.
  - cnt resets, last is unchanged.
- A request arriving from the non-granted requester during BUSY/ACK waits; it is never dropped.
- rdata registers hold their last captured value until the next completion for that requester. On writes, the captured value is don't-care.
- Reset mid-transaction: return to IDLE on the next clock, no ready, no write, last=1.
- Counter never wraps: it is cleared on leaving BUSY.

Decomposition:
- Package exmem_arb_pkg: state enum (IDLE, BUSY, ACK), requester index constants (REQ_WB=0, REQ_ACC=1), default DELAYS.
- One sub-module, exmem_rr_pick: combinational 2-way round-robin picker. Inputs are the valid vector and last; outputs are the one-hot pick and a pick_valid flag.

Test Plan:
1. DELAYS=10, BRAM word 0x10 preloaded with 0xDEADBEEF; r0 read at 0x10 from cycle t → r0_ready only at t+12, r0_rdata=0xDEADBEEF, mem_we=0 throughout, r1_ready never asserted.
2. r1 write of 0xA5A5A5A5 to 0x20 with we=4'b0011 → mem_we=0011 for exactly one cycle (t+11); r0 readback of 0x20 returns 0x????A5A5, with the upper bytes unchanged.
3. After reset, r0 and r1 both assert valid at cycle t → r0 is served first (ready at t+12), then r1 (ready at t+25); grant sequence is 01, 00, 10.
4. Both valids held high continuously, each re-requesting after its ready → grants alternate 0, 1, 0, 1 over 8 transactions; no requester is served twice in a row.
5. r1 write granted, r1_valid dropped at cnt=5 → state returns to IDLE the next cycle, no r1_ready, mem_we stays 0, memory is unchanged; a pending r0 is granted next.
6. rst asserted while BUSY at cnt=7 → next cycle all outputs are at reset values and no write occurs. The first request after rst deasserts completes with normal latency.
